// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multicycle step sequencer: opcode/func maps, ALU control codes and
// step numbers. Opcode 0111 and R funcs 0000/0110/0111 are left undefined.
package alu_seq_pkg;

  localparam logic [3:0] OpRtype = 4'h0;
  localparam logic [3:0] OpAddi  = 4'h1;
  localparam logic [3:0] OpSubi  = 4'h2;
  localparam logic [3:0] OpCmpi  = 4'h3;
  localparam logic [3:0] OpAndi  = 4'h4;
  localparam logic [3:0] OpOri   = 4'h5;
  localparam logic [3:0] OpXori  = 4'h6;
  localparam logic [3:0] OpRjmp  = 4'h8;
  localparam logic [3:0] OpJe    = 4'h9;
  localparam logic [3:0] OpJne   = 4'hA;
  localparam logic [3:0] OpJb    = 4'hB;
  localparam logic [3:0] OpJae   = 4'hC;
  localparam logic [3:0] OpJl    = 4'hD;
  localparam logic [3:0] OpRet   = 4'hE;
  localparam logic [3:0] OpRcall = 4'hF;

  localparam logic [3:0] FnAdd   = 4'h1;
  localparam logic [3:0] FnSub   = 4'h2;
  localparam logic [3:0] FnCmp   = 4'h3;
  localparam logic [3:0] FnAnd   = 4'h4;
  localparam logic [3:0] FnOr    = 4'h5;
  localparam logic [3:0] FnPush  = 4'h8;
  localparam logic [3:0] FnPushf = 4'h9;
  localparam logic [3:0] FnPop   = 4'hA;
  localparam logic [3:0] FnPopf  = 4'hB;
  localparam logic [3:0] FnXor   = 4'hC;
  localparam logic [3:0] FnLsl   = 4'hD;
  localparam logic [3:0] FnLsr   = 4'hE;
  localparam logic [3:0] FnAsr   = 4'hF;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluLsl = 3'd5,
    AluLsr = 3'd6,
    AluAsr = 3'd7
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem1   = 3'd3,
    StMem2   = 3'd4,
    StMem3   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_step_decode.sv
// Combinational step decoder: maps (opcode, func, step) to the ALU control code, the final step
// of the instruction and an undefined-encoding flag. Undefined encodings decode as a NOP.
module alu_step_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned FUNC_WIDTH   = 4,
  parameter int unsigned STATE_WIDTH  = 3,
  parameter int unsigned CTRL_WIDTH   = 3
) (
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [FUNC_WIDTH-1:0]   func_i,
  input  logic [STATE_WIDTH-1:0]  state_i,
  output logic [CTRL_WIDTH-1:0]   alu_ctrl_o,
  output logic [STATE_WIDTH-1:0]  last_state_o,
  output logic                    illegal_o
);

  alu_ctrl_e  exec_op, mem1_op, mem2_op, mem3_op, ctrl;
  seq_state_e last;

  always_comb begin
    exec_op   = AluAdd;
    mem1_op   = AluAdd;
    mem2_op   = AluAdd;
    mem3_op   = AluAdd;
    last      = StExec;
    illegal_o = 1'b0;
    case (opcode_i)
      OPCODE_WIDTH'(OpRtype): begin
        case (func_i)
          FUNC_WIDTH'(FnAdd):                      exec_op = AluAdd;
          FUNC_WIDTH'(FnSub), FUNC_WIDTH'(FnCmp):  exec_op = AluSub;
          FUNC_WIDTH'(FnAnd):                      exec_op = AluAnd;
          FUNC_WIDTH'(FnOr):                       exec_op = AluOr;
          FUNC_WIDTH'(FnXor):                      exec_op = AluXor;
          FUNC_WIDTH'(FnLsl):                      exec_op = AluLsl;
          FUNC_WIDTH'(FnLsr):                      exec_op = AluLsr;
          FUNC_WIDTH'(FnAsr):                      exec_op = AluAsr;
          FUNC_WIDTH'(FnPush), FUNC_WIDTH'(FnPushf): begin
            mem1_op = AluSub;
            last    = StMem1;
          end
          FUNC_WIDTH'(FnPop), FUNC_WIDTH'(FnPopf): begin
            exec_op = AluAdd;
            last    = StMem1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OPCODE_WIDTH'(OpAddi):                          exec_op = AluAdd;
      OPCODE_WIDTH'(OpSubi), OPCODE_WIDTH'(OpCmpi):   exec_op = AluSub;
      OPCODE_WIDTH'(OpAndi):                          exec_op = AluAnd;
      OPCODE_WIDTH'(OpOri):                           exec_op = AluOr;
      OPCODE_WIDTH'(OpXori):                          exec_op = AluXor;
      OPCODE_WIDTH'(OpRjmp), OPCODE_WIDTH'(OpJe), OPCODE_WIDTH'(OpJne),
      OPCODE_WIDTH'(OpJb), OPCODE_WIDTH'(OpJae), OPCODE_WIDTH'(OpJl): exec_op = AluAdd;
      OPCODE_WIDTH'(OpRet): begin
        exec_op = AluAdd;
        mem1_op = AluAdd;
        last    = StMem1;
      end
      OPCODE_WIDTH'(OpRcall): begin
        mem1_op = AluSub;
        mem2_op = AluAdd;
        mem3_op = AluSub;
        last    = StMem3;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Fetch and decode steps always read ADD (PC increment).
  always_comb begin
    ctrl = AluAdd;
    case (state_i)
      STATE_WIDTH'(StExec): ctrl = exec_op;
      STATE_WIDTH'(StMem1): ctrl = mem1_op;
      STATE_WIDTH'(StMem2): ctrl = mem2_op;
      STATE_WIDTH'(StMem3): ctrl = mem3_op;
      default:              ctrl = AluAdd;
    endcase
  end

  assign alu_ctrl_o   = CTRL_WIDTH'(ctrl);
  assign last_state_o = STATE_WIDTH'(last);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle step sequencer with fetch/memory stall handshakes. Define ALU_SEQ_MULTISHIFT_EN to
// hold the exec step of LSL/LSR/ASR for shamt cycles (shamt 0 counts as one).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned FUNC_WIDTH   = 4,
  parameter int unsigned STATE_WIDTH  = 3,
  parameter int unsigned CTRL_WIDTH   = 3,
  parameter int unsigned SHAMT_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [FUNC_WIDTH-1:0]   func_i,
  input  logic [SHAMT_WIDTH-1:0]  shamt_i,
  input  logic                    instr_valid_i,
  input  logic                    mem_ready_i,
  output logic                    instr_ready_o,
  output logic [STATE_WIDTH-1:0]  state_o,
  output logic [CTRL_WIDTH-1:0]   alu_ctrl_o,
  output logic                    last_step_o,
  output logic                    instr_done_o,
  output logic                    illegal_o
);

  localparam logic [STATE_WIDTH-1:0] SFetch  = STATE_WIDTH'(StFetch);
  localparam logic [STATE_WIDTH-1:0] SDecode = STATE_WIDTH'(StDecode);
  localparam logic [STATE_WIDTH-1:0] SExec   = STATE_WIDTH'(StExec);
  localparam logic [STATE_WIDTH-1:0] SMem1   = STATE_WIDTH'(StMem1);
  localparam logic [STATE_WIDTH-1:0] SMem2   = STATE_WIDTH'(StMem2);
  localparam logic [STATE_WIDTH-1:0] SMem3   = STATE_WIDTH'(StMem3);

  logic [STATE_WIDTH-1:0]  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d, dec_opcode;
  logic [FUNC_WIDTH-1:0]   func_q, func_d, dec_func;
  logic                    done_q, done_d, illegal_q, illegal_d;
  logic [STATE_WIDTH-1:0]  last_state;
  logic                    dec_illegal, latch_en, hold_shift, at_last;

  assign latch_en = (state_q == SDecode) && instr_valid_i;

  // In decode the decoder sees the incoming fields so the illegal flag is ready at latch time;
  // no opcode drives a non-ADD code in that step, so alu_ctrl is unaffected.
  assign dec_opcode = (state_q == SDecode) ? opcode_i : opcode_q;
  assign dec_func   = (state_q == SDecode) ? func_i : func_q;

  alu_step_decode #(
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .FUNC_WIDTH  (FUNC_WIDTH),
    .STATE_WIDTH (STATE_WIDTH),
    .CTRL_WIDTH  (CTRL_WIDTH)
  ) u_step_decode (
    .opcode_i    (dec_opcode),
    .func_i      (dec_func),
    .state_i     (state_q),
    .alu_ctrl_o  (alu_ctrl_o),
    .last_state_o(last_state),
    .illegal_o   (dec_illegal)
  );

`ifdef ALU_SEQ_MULTISHIFT_EN
  logic [SHAMT_WIDTH-1:0] shcnt_q, shcnt_d;
  logic                   shift_op;

  assign shift_op = (state_q == SExec) &&
                    ((alu_ctrl_o == CTRL_WIDTH'(AluLsl)) || (alu_ctrl_o == CTRL_WIDTH'(AluLsr)) ||
                     (alu_ctrl_o == CTRL_WIDTH'(AluAsr)));
  assign hold_shift = shift_op && (shcnt_q > SHAMT_WIDTH'(1));

  always_comb begin
    shcnt_d = shcnt_q;
    if (latch_en) begin
      shcnt_d = (shamt_i == '0) ? SHAMT_WIDTH'(1) : shamt_i;
    end else if ((state_q == SExec) && (shcnt_q != '0)) begin
      shcnt_d = shcnt_q - SHAMT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shcnt_q <= '0;
    else        shcnt_q <= shcnt_d;
  end
`else
  logic unused_shamt;
  assign unused_shamt = ^shamt_i;
  assign hold_shift   = 1'b0;
`endif

  assign at_last = (state_q == last_state) && !hold_shift;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    func_d    = func_q;
    done_d    = 1'b0;
    illegal_d = latch_en && dec_illegal;
    if (latch_en) begin
      opcode_d = opcode_i;
      func_d   = func_i;
    end
    case (state_q)
      SFetch:  if (mem_ready_i) state_d = SDecode;
      SDecode: if (instr_valid_i) state_d = SExec;
      SExec: begin
        if (at_last) begin
          state_d = SFetch;
          done_d  = 1'b1;
        end else if (!hold_shift) begin
          state_d = SMem1;
        end
      end
      SMem1, SMem2, SMem3: begin
        if (mem_ready_i) begin
          if (at_last) begin
            state_d = SFetch;
            done_d  = 1'b1;
          end else begin
            state_d = state_q + STATE_WIDTH'(1);
          end
        end
      end
      default: state_d = SFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SFetch;
      opcode_q  <= '0;
      func_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      func_q    <= func_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign state_o       = state_q;
  assign instr_ready_o = (state_q == SDecode);
  assign last_step_o   = at_last;
  assign instr_done_o  = done_q;
  assign illegal_o     = illegal_q;

endmodule
